viterbi_ber_checker: RTL and testbench
======================================

Name: viterbi_ber_checker

Overview:
Downstream stage of the encoder / channel / Viterbi decoder chain; measures end-to-end bit error rate.
- Captures each source bit presented to the encoder and delays it by the fixed decoder latency.
- Compares the delayed bit against the decoder output and accumulates bit, error and burst statistics.
- Flags loss of alignment when errors run consecutively.

Parameters:
LATENCY, 20, clocks from source bit accepted (ref_valid_i high) to the matching decoded bit on dec_bit_i; legal range 1..255
CNT_W, 32, width of bit and error counters
LOSS_THRESH, 8, consecutive mismatches that declare loss of sync; legal range 1..255

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
start_i  in  1  one-cycle pulse: clear statistics, begin measurement
stop_i  in  1  one-cycle pulse: end measurement, freeze statistics
ref_valid_i  in  1  source bit valid (same qualifier as encoder enable)
ref_bit_i  in  1  source bit fed to the encoder
dec_bit_i  in  1  decoder output bit
bit_ct_o  out  CNT_W  bits compared
err_ct_o  out  CNT_W  mismatches counted
max_burst_o  out  8  longest run of consecutive mismatches
synced_o  out  1  high in CHECK state
lost_o  out  1  sticky loss-of-sync flag
busy_o  out  1  high in FILL or CHECK

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset: all outputs 0, state IDLE, delay lines 0, burst counter 0.
- Delay line:
  - LATENCY-deep shift registers for ref_bit_i and ref_valid_i.
  - Shift every clock in every state; not gated by state.
  - Delayed valid = dv, delayed bit = db.
  - Compare event = CHECK state and dv=1. No event when dv=0; decoder output is ignored then.
- States:
  - IDLE: outputs hold. start_i -> FILL; clear bit_ct, err_ct, max_burst, cur_burst, lost_o; load fill counter with LATENCY.
  - FILL: fill counter decrements each clock; at 0 -> CHECK. Window = exactly LATENCY clocks after the start_i cycle. No comparisons during FILL.
  - CHECK: on each compare event:
    - bit_ct += 1.
    - If dec_bit_i != db: err_ct += 1, cur_burst += 1, max_burst = max(max_burst, cur_burst+1).
    - Else cur_burst = 0.
    - If the incremented cur_burst equals LOSS_THRESH: -> LOST, lost_o=1. The mismatch on that cycle is counted.
  - LOST: counters frozen, lost_o stays 1, synced_o=0, busy_o=0.
- Transitions out of states:
  - stop_i in FILL or CHECK -> IDLE, counters hold. A compare event in the same cycle as stop_i is still counted.
  - start_i in any non-IDLE state restarts the same way as from IDLE.
  - start_i and stop_i in the same cycle: start_i wins.
- Arithmetic:
  - bit_ct and err_ct saturate at all-ones and never wrap.
  - cur_burst and max_burst are 8 bits and saturate at 255.
  - err_ct <= bit_ct always.
- Outputs are registered; they reflect an event one clock after the compare cycle.
- Reset asserted mid-measurement: immediate return to reset values; no partial statistics retained.

Test Plan:
1. Clean channel, LATENCY=20: start_i, then 1000 valid random bits with dec_bit_i = ref_bit_i delayed 20 -> bit_ct=1000, err_ct=0, max_burst=0, synced_o=1, lost_o=0.
2. Error injection: invert dec_bit_i on compare events 100 and 500–502 (ref_valid_i continuous) -> err_ct=4, max_burst=3, lost_o=0.
3. Loss of sync, LOSS_THRESH=8: invert dec_bit_i continuously from compare event 50 -> LOST entered on event 57, err_ct=8, bit_ct=57, lost_o=1, counters static afterwards.
4. Gapped valid: ref_valid_i toggling 1,0,1,0 for 200 clocks, with dec_bit_i held at the complement of db on invalid cycles -> bit_ct=100, err_ct=0.
5. Control corners:
   - stop_i on a compare cycle -> that bit counted; IDLE next.
   - start_i+stop_i same cycle -> FILL, counters 0.
   - start_i during LOST -> lost_o=0, busy_o=1.
   - rst pulse mid-CHECK -> all outputs 0 next clock.
6. Saturation, CNT_W=4: 20 compare events all mismatched with LOSS_THRESH=255 -> bit_ct=15, err_ct=15, max_burst=20.

Source files
------------

// File: rtl/viterbi_ber_checker.sv
// viterbi_ber_checker: end-to-end BER monitor for the encoder/channel/Viterbi chain.
// Delays source bits by LATENCY clocks, compares them with decoded bits, and accumulates statistics.
// Ports: clk, rst (async, active-high); start_i/stop_i measurement control;
//   ref_valid_i/ref_bit_i source side; dec_bit_i decoder output;
//   bit_ct_o/err_ct_o/max_burst_o statistics; synced_o/lost_o/busy_o status.
module viterbi_ber_checker #(
   parameter int LATENCY     = 20,
   parameter int CNT_W       = 32,
   parameter int LOSS_THRESH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic             ref_valid_i,
   input  logic             ref_bit_i,
   input  logic             dec_bit_i,
   output logic [CNT_W-1:0] bit_ct_o,
   output logic [CNT_W-1:0] err_ct_o,
   output logic [7:0]       max_burst_o,
   output logic             synced_o,
   output logic             lost_o,
   output logic             busy_o
);

   typedef enum logic [1:0] {IDLE, FILL, CHECK, LOST} state_t;

   state_t             state_q, state_d;
   logic [LATENCY-1:0] vsr_q, bsr_q;
   logic [7:0]         fill_q, fill_d;
   logic [CNT_W-1:0]   bit_q, bit_d;
   logic [CNT_W-1:0]   err_q, err_d;
   logic [7:0]         max_q, max_d;
   logic [7:0]         cur_q, cur_d;
   logic               lost_q, lost_d;

   logic       dv, db, ev, mis;
   logic [7:0] cur_inc;

   assign dv  = vsr_q[LATENCY-1];
   assign db  = bsr_q[LATENCY-1];
   assign ev  = (state_q == CHECK) && dv;
   assign mis = dec_bit_i ^ db;
   // Burst length including this cycle's mismatch, saturating at 255
   assign cur_inc = (&cur_q) ? cur_q : cur_q + 8'd1;

   always_comb begin
      state_d = state_q;
      fill_d  = fill_q;
      bit_d   = bit_q;
      err_d   = err_q;
      max_d   = max_q;
      cur_d   = cur_q;
      lost_d  = lost_q;

      unique case (state_q)
         IDLE: ;
         FILL: begin
            if (fill_q <= 8'd1) begin
               fill_d  = 8'd0;
               state_d = CHECK;
            end else begin
               fill_d = fill_q - 8'd1;
            end
            if (stop_i) state_d = IDLE;
         end
         CHECK: begin
            if (ev) begin
               if (!(&bit_q)) bit_d = bit_q + 1'b1;
               if (mis) begin
                  if (!(&err_q)) err_d = err_q + 1'b1;
                  cur_d = cur_inc;
                  if (cur_inc > max_q) max_d = cur_inc;
               end else begin
                  cur_d = 8'd0;
               end
            end
            // Loss of sync outranks a concurrent stop so the sticky flag is not orphaned
            if (ev && mis && (cur_inc == 8'(LOSS_THRESH))) begin
               state_d = LOST;
               lost_d  = 1'b1;
            end else if (stop_i) begin
               state_d = IDLE;
            end
         end
         LOST: ;
         default: state_d = IDLE;
      endcase

      // Restart from any state; overrides stop and any compare in this cycle
      if (start_i) begin
         state_d = FILL;
         fill_d  = 8'(LATENCY);
         bit_d   = '0;
         err_d   = '0;
         max_d   = 8'd0;
         cur_d   = 8'd0;
         lost_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         vsr_q   <= '0;
         bsr_q   <= '0;
         fill_q  <= 8'd0;
         bit_q   <= '0;
         err_q   <= '0;
         max_q   <= 8'd0;
         cur_q   <= 8'd0;
         lost_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         vsr_q[0] <= ref_valid_i;
         bsr_q[0] <= ref_bit_i;
         for (int i = 1; i < LATENCY; i++) begin
            vsr_q[i] <= vsr_q[i-1];
            bsr_q[i] <= bsr_q[i-1];
         end
         fill_q <= fill_d;
         bit_q  <= bit_d;
         err_q  <= err_d;
         max_q  <= max_d;
         cur_q  <= cur_d;
         lost_q <= lost_d;
      end
   end

   assign bit_ct_o    = bit_q;
   assign err_ct_o    = err_q;
   assign max_burst_o = max_q;
   assign synced_o    = (state_q == CHECK);
   assign lost_o      = lost_q;
   assign busy_o      = (state_q == FILL) || (state_q == CHECK);

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Directed bench for viterbi_ber_checker: default instance plus a CNT_W=4,
// LOSS_THRESH=255 instance sharing the same stimulus for saturation.
module tb_viterbi_ber_checker;

   logic clk = 1'b0;
   logic rst, start_i, stop_i, ref_valid_i, ref_bit_i, dec_bit_i;

   logic [31:0] bit_ct, err_ct;
   logic [7:0]  max_b;
   logic        synced, lost, busy;

   logic [3:0]  s_bit, s_err;
   logic [7:0]  s_max;
   logic        s_sync, s_lost, s_busy;

   always #5 clk = ~clk;

   viterbi_ber_checker u_dut (
      .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i),
      .ref_valid_i(ref_valid_i), .ref_bit_i(ref_bit_i), .dec_bit_i(dec_bit_i),
      .bit_ct_o(bit_ct), .err_ct_o(err_ct), .max_burst_o(max_b),
      .synced_o(synced), .lost_o(lost), .busy_o(busy)
   );

   viterbi_ber_checker #(.LATENCY(20), .CNT_W(4), .LOSS_THRESH(255)) u_sat (
      .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i),
      .ref_valid_i(ref_valid_i), .ref_bit_i(ref_bit_i), .dec_bit_i(dec_bit_i),
      .bit_ct_o(s_bit), .err_ct_o(s_err), .max_burst_o(s_max),
      .synced_o(s_sync), .lost_o(s_lost), .busy_o(s_busy)
   );

   int checks = 0;
   int passed = 0;

   // Bench-side delay model: front entry is the value driven 20 steps ago
   logic bq[$];
   logic vq[$];
   int   since, evn, e1, e2lo, e2hi, efrom, mode;
   bit   act;

   task automatic model_reset();
      bq = {};
      vq = {};
      for (int i = 0; i < 20; i++) begin
         bq.push_back(1'b0);
         vq.push_back(1'b0);
      end
      act = 0;
      since = 0;
      evn = 0;
   endtask

   task automatic set_inv(input int a, input int lo, input int hi, input int from);
      e1 = a;
      e2lo = lo;
      e2hi = hi;
      efrom = from;
   endtask

   task automatic step(input logic v, input logic st, input logic sp);
      logic b, dv, inv;
      b = 1'($urandom_range(0, 1));
      ref_valid_i = v;
      ref_bit_i = b;
      start_i = st;
      stop_i = sp;
      if (st) begin
         since = 0;
         act = 1;
         evn = 0;
      end else begin
         since++;
      end
      dv = vq[0];
      inv = 1'b0;
      if (act && since >= 21 && dv) begin
         evn++;
         inv = (evn == e1) || (evn >= e2lo && evn <= e2hi) || (evn >= efrom);
      end
      if (mode == 1 && !dv) inv = 1'b1;
      dec_bit_i = bq[0] ^ inv;
      @(posedge clk);
      #1;
      if (sp && !st) act = 0;
      void'(bq.pop_front());
      void'(vq.pop_front());
      bq.push_back(b);
      vq.push_back(v);
      start_i = 1'b0;
      stop_i = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start_i = 0; stop_i = 0; ref_valid_i = 0; ref_bit_i = 0; dec_bit_i = 0;
      mode = 0;
      set_inv(0, 1, 0, 1 << 30);
      model_reset();
      #12;
      checks++;
      if ({bit_ct, err_ct, max_b, synced, lost, busy} !== '0)
         $display("FAIL reset_outputs got bit=%0d err=%0d max=%0d s=%b l=%b b=%b want all 0",
                  bit_ct, err_ct, max_b, synced, lost, busy);
      else passed++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_clean();
      set_inv(0, 1, 0, 1 << 30);
      step(0, 1, 0);
      checks++;
      if (busy !== 1'b1 || synced !== 1'b0)
         $display("FAIL clean_fill_state got busy=%b synced=%b want 1 0", busy, synced);
      else passed++;
      repeat (1000) step(1, 0, 0);
      repeat (20) step(0, 0, 0);
      checks++;
      if (bit_ct !== 32'd1000) $display("FAIL clean_bit_ct got %0d want 1000", bit_ct);
      else passed++;
      checks++;
      if (err_ct !== 32'd0 || max_b !== 8'd0)
         $display("FAIL clean_err got err=%0d max=%0d want 0 0", err_ct, max_b);
      else passed++;
      checks++;
      if (synced !== 1'b1 || lost !== 1'b0)
         $display("FAIL clean_status got synced=%b lost=%b want 1 0", synced, lost);
      else passed++;
   endtask

   task automatic test_errors();
      set_inv(100, 500, 502, 1 << 30);
      step(0, 1, 0);
      repeat (1000) step(1, 0, 0);
      repeat (20) step(0, 0, 0);
      checks++;
      if (err_ct !== 32'd4) $display("FAIL inject_err_ct got %0d want 4", err_ct);
      else passed++;
      checks++;
      if (max_b !== 8'd3) $display("FAIL inject_max_burst got %0d want 3", max_b);
      else passed++;
      checks++;
      if (bit_ct !== 32'd1000 || lost !== 1'b0)
         $display("FAIL inject_bits got bit=%0d lost=%b want 1000 0", bit_ct, lost);
      else passed++;
   endtask

   task automatic test_loss();
      set_inv(0, 1, 0, 50);
      step(0, 1, 0);
      repeat (100) step(1, 0, 0);
      checks++;
      if (bit_ct !== 32'd57 || err_ct !== 32'd8)
         $display("FAIL loss_counts got bit=%0d err=%0d want 57 8", bit_ct, err_ct);
      else passed++;
      checks++;
      if (lost !== 1'b1 || synced !== 1'b0 || busy !== 1'b0)
         $display("FAIL loss_flags got lost=%b synced=%b busy=%b want 1 0 0", lost, synced, busy);
      else passed++;
      checks++;
      if (max_b !== 8'd8) $display("FAIL loss_max_burst got %0d want 8", max_b);
      else passed++;
      repeat (10) step(1, 0, 0);
      checks++;
      if (bit_ct !== 32'd57 || err_ct !== 32'd8 || lost !== 1'b1)
         $display("FAIL loss_frozen got bit=%0d err=%0d lost=%b want 57 8 1", bit_ct, err_ct, lost);
      else passed++;
   endtask

   task automatic test_gapped();
      set_inv(0, 1, 0, 1 << 30);
      mode = 1;
      step(0, 1, 0);
      for (int i = 0; i < 200; i++) step(logic'(i % 2 == 0), 0, 0);
      repeat (20) step(0, 0, 0);
      mode = 0;
      checks++;
      if (bit_ct !== 32'd100 || err_ct !== 32'd0)
         $display("FAIL gapped_counts got bit=%0d err=%0d want 100 0", bit_ct, err_ct);
      else passed++;
   endtask

   task automatic test_control();
      set_inv(0, 1, 0, 1 << 30);
      step(0, 1, 0);
      repeat (22) step(1, 0, 0);
      step(1, 0, 1);
      checks++;
      if (bit_ct !== 32'd3 || busy !== 1'b0 || synced !== 1'b0)
         $display("FAIL stop_on_compare got bit=%0d busy=%b synced=%b want 3 0 0",
                  bit_ct, busy, synced);
      else passed++;
      step(1, 0, 0);
      checks++;
      if (bit_ct !== 32'd3) $display("FAIL stop_hold got %0d want 3", bit_ct);
      else passed++;

      step(1, 1, 1);
      checks++;
      if (busy !== 1'b1 || synced !== 1'b0 || bit_ct !== 32'd0 || err_ct !== 32'd0)
         $display("FAIL start_stop_same got busy=%b synced=%b bit=%0d err=%0d want 1 0 0 0",
                  busy, synced, bit_ct, err_ct);
      else passed++;

      set_inv(0, 1, 0, 1);
      repeat (40) step(1, 0, 0);
      checks++;
      if (lost !== 1'b1 || busy !== 1'b0)
         $display("FAIL corner_lost got lost=%b busy=%b want 1 0", lost, busy);
      else passed++;
      set_inv(0, 1, 0, 1 << 30);
      step(1, 1, 0);
      checks++;
      if (lost !== 1'b0 || busy !== 1'b1)
         $display("FAIL start_from_lost got lost=%b busy=%b want 0 1", lost, busy);
      else passed++;

      repeat (30) step(1, 0, 0);
      checks++;
      if (bit_ct !== 32'd10 || synced !== 1'b1)
         $display("FAIL pre_rst_check got bit=%0d synced=%b want 10 1", bit_ct, synced);
      else passed++;
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({bit_ct, err_ct, max_b, synced, lost, busy} !== '0)
         $display("FAIL mid_rst got bit=%0d err=%0d max=%0d s=%b l=%b b=%b want all 0",
                  bit_ct, err_ct, max_b, synced, lost, busy);
      else passed++;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_saturation();
      set_inv(0, 1, 0, 1);
      step(0, 1, 0);
      repeat (20) step(1, 0, 0);
      repeat (20) step(0, 0, 0);
      checks++;
      if (s_bit !== 4'd15 || s_err !== 4'd15)
         $display("FAIL sat_counts got bit=%0d err=%0d want 15 15", s_bit, s_err);
      else passed++;
      checks++;
      if (s_max !== 8'd20 || s_lost !== 1'b0)
         $display("FAIL sat_burst got max=%0d lost=%b want 20 0", s_max, s_lost);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_clean();
      test_errors();
      test_loss();
      test_gapped();
      test_control();
      test_saturation();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
